// File: rtl/bandai2003_pkg.sv
// Shared constants, state encoding and error codes for the Bandai 2003 host unlock block.
package bandai2003_pkg;

    localparam logic [7:0] ADDR_ACK = 8'h5A;
    localparam logic [7:0] ADDR_NAK = 8'hA5;
    localparam logic [7:0] ADDR_NIH = 8'hFF;

    // One start bit, sixteen payload bits, one stop bit.
    localparam int FRAME_BITS = 18;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    typedef enum logic [2:0] {
        IDLE,
        SEND_ACK,
        SEND_NAK,
        WAIT_START,
        SHIFT,
        STOP,
        DONE_S,
        FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_DATA    = 2'b11;

endpackage

// File: rtl/bandai2003_host_unlock_if.sv
// Cartridge-port / system-control signal bundle for the host unlock block.
interface bandai2003_host_unlock_if;

    logic        START;
    logic [7:0]  ADDR_O;
    logic        SI;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  ERR;
    logic [15:0] RX_WORD;
    logic        CTRL1_B7;

    // slave: the unlock block itself; master: the system side driving it.
    modport slave (
        input  START, SI,
        output ADDR_O, BUSY, DONE, ERR, RX_WORD, CTRL1_B7
    );

    modport master (
        output START, SI,
        input  ADDR_O, BUSY, DONE, ERR, RX_WORD, CTRL1_B7
    );

endinterface

// File: rtl/bandai2003_serial_rx.sv
// Start detect, LSB-first payload shift, stop check and start timeout for the cartridge stream.
// Optional macro SI_SYNC_EN inserts a 2-flop synchronizer on SI.
module bandai2003_serial_rx
    import bandai2003_pkg::*;
#(
    parameter int          TIMEOUT = 64,
    parameter logic [15:0] EXPECT  = 16'h28A0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  state_t               state,
    input  logic                 clear,
    input  logic                 si,
    output logic                 start_det,
    output logic                 last_bit,
    output logic                 rx_ok,
    output logic                 rx_fail,
    output logic [1:0]           rx_err,
    output logic [DATA_BITS-1:0] word
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DATA_BITS);

    logic                 si_s;
    logic [CW-1:0]        tmo_reg;
    logic [BW-1:0]        bit_reg;
    logic [DATA_BITS-1:0] word_reg;
    logic                 timeout_hit;
    logic                 stop_bad;

`ifdef SI_SYNC_EN
    logic [1:0] sync_reg;

    // Reset to the pull-up level so a fresh attempt never sees a phantom start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], si};
        end
    end

    assign si_s = sync_reg[1];
`else
    assign si_s = si;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_reg  <= '0;
            bit_reg  <= '0;
            word_reg <= '0;
        end else begin
            if (state == SEND_NAK) begin
                tmo_reg <= '0;
            end else if (state == WAIT_START && si_s && tmo_reg != CW'(TIMEOUT)) begin
                tmo_reg <= tmo_reg + 1'b1;
            end

            if (start_det) begin
                bit_reg <= '0;
            end else if (state == SHIFT) begin
                bit_reg <= bit_reg + 1'b1;
            end

            if (clear) begin
                word_reg <= '0;
            end else if (state == SHIFT) begin
                word_reg <= {si_s, word_reg[DATA_BITS-1:1]};
            end
        end
    end

    assign start_det   = (state == WAIT_START) && !si_s;
    assign timeout_hit = (state == WAIT_START) && si_s && (tmo_reg == CW'(TIMEOUT - 1));
    assign last_bit    = (state == SHIFT) && (bit_reg == BW'(DATA_BITS - 1));
    assign stop_bad    = (state == STOP) && (si_s || word_reg != EXPECT);

    assign rx_ok   = (state == STOP) && !si_s && (word_reg == EXPECT);
    assign rx_fail = timeout_hit || stop_bad;
    assign rx_err  = timeout_hit ? ERR_TIMEOUT : (si_s ? ERR_STOP : ERR_DATA);
    assign word    = word_reg;

endmodule

// File: rtl/bandai2003_host_unlock.sv
// Console-side initiator: sends the 5Ah/A5h unlock addresses, receives the cartridge reply
// and raises the SYSTEM_CTRL1 bit-7 grant. Optional macro SI_SYNC_EN (see bandai2003_serial_rx).
module bandai2003_host_unlock
    import bandai2003_pkg::*;
#(
    parameter int          TIMEOUT = 64,
    parameter logic [15:0] EXPECT  = 16'h28A0
) (
    input  logic                     CLK,
    input  logic                     RST,
    bandai2003_host_unlock_if.slave  bus
);

    state_t      state_reg;
    logic [7:0]  addr_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [1:0]  err_reg;
    logic        ctrl1_b7_reg;

    logic        clear;
    logic        start_det;
    logic        last_bit;
    logic        rx_ok;
    logic        rx_fail;
    logic [1:0]  rx_err;
    logic [15:0] word;

    assign clear = (state_reg == IDLE) && bus.START;

    bandai2003_serial_rx #(
        .TIMEOUT (TIMEOUT),
        .EXPECT  (EXPECT)
    ) u_rx (
        .CLK       (CLK),
        .RST       (RST),
        .state     (state_reg),
        .clear     (clear),
        .si        (bus.SI),
        .start_det (start_det),
        .last_bit  (last_bit),
        .rx_ok     (rx_ok),
        .rx_fail   (rx_fail),
        .rx_err    (rx_err),
        .word      (word)
    );

    // Outputs are loaded together with the next state so they track it without glitches.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            addr_reg     <= ADDR_NIH;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= ERR_NONE;
            ctrl1_b7_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.START) begin
                        state_reg <= SEND_ACK;
                        addr_reg  <= ADDR_ACK;
                        busy_reg  <= 1'b1;
                        err_reg   <= ERR_NONE;
                    end
                end
                SEND_ACK: begin
                    state_reg <= SEND_NAK;
                    addr_reg  <= ADDR_NAK;
                end
                SEND_NAK: begin
                    state_reg <= WAIT_START;
                    addr_reg  <= ADDR_NIH;
                end
                WAIT_START: begin
                    if (start_det) begin
                        state_reg <= SHIFT;
                    end else if (rx_fail) begin
                        state_reg <= FAIL;
                        busy_reg  <= 1'b0;
                        err_reg   <= rx_err;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    busy_reg <= 1'b0;
                    if (rx_ok) begin
                        state_reg    <= DONE_S;
                        done_reg     <= 1'b1;
                        ctrl1_b7_reg <= 1'b1;
                    end else begin
                        state_reg <= FAIL;
                        err_reg   <= rx_err;
                    end
                end
                // The cartridge lock is one-shot: only reset leaves DONE_S or FAIL.
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign bus.ADDR_O   = addr_reg;
    assign bus.BUSY     = busy_reg;
    assign bus.DONE     = done_reg;
    assign bus.ERR      = err_reg;
    assign bus.RX_WORD  = word;
    assign bus.CTRL1_B7 = ctrl1_b7_reg;

endmodule

// File: tb/tb_bandai2003_host_unlock.sv
// Randomized self-checking bench for bandai2003_host_unlock with a behavioural cartridge model.
module tb_bandai2003_host_unlock;

    localparam logic [15:0] EXPECT  = 16'h28A0;
    localparam int          TIMEOUT = 64;
`ifdef SI_SYNC_EN
    localparam int LAT = 23;
`else
    localparam int LAT = 21;
`endif

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    int   txn;

    bandai2003_host_unlock_if bus ();

    bandai2003_host_unlock #(
        .TIMEOUT (TIMEOUT),
        .EXPECT  (EXPECT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cartridge model configuration.
    bit          cart_silent;
    logic [15:0] cart_payload;
    bit          cart_stop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s txn %0d got %h expected %h", tag, txn, got, exp);
        end
    endtask

    // Cartridge: after seeing 5Ah then A5h on consecutive cycles it shifts out
    // {stop, payload, start} LSB-first, one bit per clock; otherwise SI floats high.
    initial begin : cartridge
        logic [7:0]  h1;
        logic [7:0]  h2;
        logic [17:0] frame;
        int          left;
        bit          used;
        h1 = 8'hFF; h2 = 8'hFF; frame = '1; left = 0; used = 0;
        bus.SI = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                left = 0; used = 0; h1 = 8'hFF; h2 = 8'hFF;
                bus.SI = 1'b1;
            end else begin
                if (!used && h2 == 8'h5A && h1 == 8'hA5) begin
                    used = 1;
                    if (!cart_silent) begin
                        frame = {cart_stop, cart_payload, 1'b0};
                        left  = 18;
                    end
                end
                if (left > 0) begin
                    bus.SI = frame[18 - left];
                    left--;
                end else begin
                    bus.SI = 1'b1;
                end
                h2 = h1;
                h1 = bus.ADDR_O;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_addr", 32'(bus.ADDR_O), 32'hFF);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);
        chk("rst_rxword", 32'(bus.RX_WORD), 32'd0);
        chk("rst_ctrl1b7", 32'(bus.CTRL1_B7), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_reset_vals();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // abort_n: cycle after START at which RST is pulsed (0 = never).
    // repulse: pulse START again in the middle of the payload shift.
    task automatic run_txn(input bit sil, input logic [15:0] pl, input bit stp,
                           input int abort_n, input bit repulse);
        int          n;
        int          n_end;
        int          e_n;
        logic [1:0]  e_err;
        logic [15:0] e_rx;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic [7:0]  a3;
        cart_silent  = sil;
        cart_payload = pl;
        cart_stop    = stp;
        txn++;

        // Reference outcome from the handshake rules.
        if (sil)              e_err = 2'b01;
        else if (stp)         e_err = 2'b10;
        else if (pl != EXPECT) e_err = 2'b11;
        else                  e_err = 2'b00;
        e_n  = sil ? TIMEOUT + 3 : LAT;
        e_rx = sil ? 16'h0000 : pl;

        @(negedge CLK);
        bus.START = 1'b1;
        n = 0; n_end = 0; a1 = '0; a2 = '0; a3 = '0;
        while (n < 120 && n_end == 0) begin
            @(negedge CLK);
            n++;
            bus.START = repulse && (n == 8);
            if (n == 1) a1 = bus.ADDR_O;
            if (n == 2) a2 = bus.ADDR_O;
            if (n == 3) a3 = bus.ADDR_O;
            if (n == abort_n) begin
                RST = 1'b1;
                #1;
                check_reset_vals();
                @(negedge CLK);
                @(negedge CLK);
                RST = 1'b0;
                $display("txn %0d aborted by reset at cycle %0d", txn, n);
                return;
            end
            if (!bus.BUSY) n_end = n;
        end
        chk("addr_ack", 32'(a1), 32'h5A);
        chk("addr_nak", 32'(a2), 32'hA5);
        chk("addr_idle", 32'(a3), 32'hFF);
        chk("finish_cycle", 32'(n_end), 32'(e_n));
        chk("err", 32'(bus.ERR), 32'(e_err));
        chk("done", 32'(bus.DONE), 32'(e_err == 2'b00));
        chk("ctrl1b7", 32'(bus.CTRL1_B7), 32'(e_err == 2'b00));
        chk("rxword", 32'(bus.RX_WORD), 32'(e_rx));

        // Terminal state must ignore a new START.
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("term_busy", 32'(bus.BUSY), 32'd0);
        chk("term_addr", 32'(bus.ADDR_O), 32'hFF);
        chk("term_rxword", 32'(bus.RX_WORD), 32'(e_rx));
        chk("term_done", 32'(bus.DONE), 32'(e_err == 2'b00));
        $display("txn %0d payload %h stop %0d silent %0d -> err %0d done %0d cycles %0d",
                 txn, pl, stp, sil, bus.ERR, bus.DONE, n_end);
    endtask

    initial begin : main
        bit          sil;
        bit          stp;
        logic [15:0] pl;
        checks = 0; errors = 0; txn = 0;
        RST = 1'b1;
        bus.START = 1'b0;
        cart_silent = 0; cart_payload = EXPECT; cart_stop = 0;

        do_reset();
        run_txn(0, EXPECT, 0, 0, 0);
        do_reset();
        run_txn(1, EXPECT, 0, 0, 0);
        do_reset();
        run_txn(0, 16'h28A1, 0, 0, 0);
        do_reset();
        run_txn(0, EXPECT, 1, 0, 0);
        do_reset();
        run_txn(0, EXPECT, 0, LAT - 9, 0);
        run_txn(0, EXPECT, 0, 0, 1);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            sil = ($urandom_range(7) == 0);
            stp = ($urandom_range(3) == 0);
            pl  = ($urandom_range(1) == 1) ? EXPECT : 16'($urandom);
            repeat ($urandom_range(3)) @(negedge CLK);
            run_txn(sil, pl, stp, 0, ($urandom_range(1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bandai2003_host_unlock.md
Name: bandai2003_host_unlock

Overview:
- Console-side initiator for the Bandai 2003 cartridge unlock and boot handshake.
- On START it drives the two-step unlock address sequence (5Ah, then A5h) on the cartridge address bus.
- It then receives the framed 18-bit bit-stream the cartridge returns on its synchronous serial out, compares the payload with the expected command, and asserts the SYSTEM_CTRL1 bit-7 request.
- Sits in the console system-control block, between the cartridge port pins and the SYSTEM_CTRL1 (A0h) register.

Parameters:
- TIMEOUT, 64, max CLK cycles spent in WAIT_START before failing.
- EXPECT, 16'h28A0, payload that grants CTRL1_B7.

Ports:
- CLK  in  1  system clock, shared with the cartridge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse that begins the sequence; ignored unless state is IDLE.
- ADDR_O  out  8  cartridge address bus (A-1..A3, A15..A18); reset 8'hFF.
- SI  in  1  cartridge serial out; board pull-up, so high-Z reads as 1.
- BUSY  out  1  high in every state except IDLE, DONE and FAIL; reset 0.
- DONE  out  1  sticky success flag; reset 0.
- ERR  out  2  00 none, 01 start timeout, 10 bad stop bit, 11 payload mismatch; reset 00.
- RX_WORD  out  16  last received payload; reset 16'h0000.
- CTRL1_B7  out  1  sticky grant, set when DONE is set with a matching payload; reset 0.

Behaviour:
- Reset is asynchronous and active-high, and is the only mechanism that clears any output.
- States: IDLE, SEND_ACK, SEND_NAK, WAIT_START, SHIFT, STOP, DONE_S, FAIL.
- ADDR_O is 8'h5A in SEND_ACK, 8'h A5 in SEND_NAK (written 8'hA5), and 8'hFF in all other states. FFh never matches an unlock address.
- IDLE: on START go to SEND_ACK; clear ERR and RX_WORD.
- SEND_ACK lasts exactly 1 cycle, then SEND_NAK.
- SEND_NAK lasts exactly 1 cycle; the cartridge loads its shift register at that edge. Then WAIT_START with the timeout counter cleared.
- WAIT_START: sample SI every posedge.
  - SI==0 → SHIFT with bit count 0.
  - Otherwise increment the counter; on reaching TIMEOUT → FAIL with ERR=01.
  - Nominal path with no synchronizer: start bit seen on the 1st WAIT_START edge.
- SHIFT: every edge, RX_WORD <= {SI, RX_WORD[15:1]} (LSB-first). After 16 samples go to STOP.
- STOP: sample SI.
  - SI==1 → FAIL, ERR=10.
  - SI==0 and RX_WORD==EXPECT → DONE_S; set DONE and CTRL1_B7.
  - SI==0 and RX_WORD!=EXPECT → FAIL, ERR=11.
- Nominal latency: START edge to DONE high is 21 cycles (1 IDLE + 2 send + 1 start + 16 data + 1 stop).
- DONE_S and FAIL are terminal; START is ignored in both. The cartridge lock is one-shot, so only RST re-arms the block.
- START asserted while BUSY is ignored, with no effect on the counter or the data.
- RST mid-sequence returns to IDLE immediately with all outputs at reset values. The cartridge must also be reset before a new attempt; the system reset tree ties both resets together.
- The timeout counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Optional Feature:
- Macro SI_SYNC_EN.
- Defined: SI passes through a 2-flop synchronizer before use. The start bit then arrives on the 3rd WAIT_START edge, and the nominal latency becomes 23 cycles. Framing and data order are unchanged, and the timeout still counts from WAIT_START entry.
- Undefined: SI is sampled directly, relying on the shared CLK; nominal latency is 21 cycles.

Decomposition:
- Package bandai2003_pkg holds:
  - ADDR_ACK=8'h5A, ADDR_NAK=8'hA5, ADDR_NIH=8'hFF.
  - FRAME_BITS=18.
  - The state enum.
  - The ERR code constants.
- One natural sub-module, bandai2003_serial_rx: start detect, 16-bit shift, stop check, timeout. It reports payload and error to the top FSM, which owns the address sequencing and the flags.

Test Plan:
- Nominal: model a cartridge that returns {0,16'h28A0,0} after 5A/A5 → ADDR_O shows 5A then A5 on consecutive cycles; DONE=1, CTRL1_B7=1, RX_WORD=28A0, ERR=00 at cycle 21.
- Silent cartridge (SI stuck 1) → FAIL after 64 WAIT_START cycles; ERR=01, CTRL1_B7=0, BUSY=0.
- Payload 16'h28A1 → ERR=11, RX_WORD=28A1, DONE=0, CTRL1_B7=0.
- Stop bit forced 1 → ERR=10, DONE=0.
- RST pulsed during SHIFT bit 7 → all outputs at reset values; a fresh START with a reset cartridge model reaches DONE again.
- START re-pulsed during SHIFT and after DONE → no state change, and RX_WORD is unchanged. With SI_SYNC_EN defined, the nominal case passes at cycle 23.
